sp_ram_arbiter: RTL
===================

// Module: sp_ram_arbiter
// PURPOSE
//  Shares one synchronous single-port N x 32bit byte-enable RAM among NUM_PORTS requesters.
//  Uses round-robin arbitration with per-port req/gnt/rvalid handshakes.
//  Contains a clear engine that sweeps the whole RAM with CLEAR_VAL on command or after reset.
//  Sits between the bus-side requesters and the RAM macro; the RAM is instantiated outside this block.
// PARAMETERS
//  NUM_PORTS      2             number of requesters (>=1)
//  ADDR_WIDTH     10            RAM address width
//  DATA_DEPTH     1024          RAM words (<= 2**ADDR_WIDTH)
//  OUT_REGS       0             must match the RAM's OUT_REGS; read latency RD_LAT = 1+OUT_REGS
//  CLEAR_VAL      32'h0         word written by the clear engine
//  CLEAR_ON_RST   0             1: start a clear sweep automatically when reset is released
// PORTS
//  Clk_CI       in   1                  clock
//  Rst_SI       in   1                  reset, synchronous, active-high
//  Clear_SI     in   1                  pulse: start a clear sweep
//  Busy_SO      out  1                  clear sweep in progress
//  Req_SI       in   NUM_PORTS          per-port request
//  Gnt_SO       out  NUM_PORTS          per-port grant, one-hot or zero
//  WrEn_SI      in   NUM_PORTS          per-port write (1) / read (0)
//  BEn_SI       in   NUM_PORTS x 4      per-port byte enables
//  WrData_DI    in   NUM_PORTS x 32     per-port write data
//  Addr_DI      in   NUM_PORTS x AW     per-port word address
//  RValid_SO    out  NUM_PORTS          per-port response strobe
//  RdData_DO    out  32                 response data, broadcast to all ports
//  RamCSel_SO   out  1                  RAM chip select
//  RamWrEn_SO   out  1                  RAM write enable
//  RamBEn_SO    out  4                  RAM byte enables
//  RamWrData_DO out  32                 RAM write data
//  RamAddr_DO   out  AW                 RAM address
//  RamRdData_DI in   32                 RAM read data
// BEHAVIOUR
//  Reset (Rst_SI=1 at a clock edge):
//   - state<=IDLE, rr pointer<=0, rvalid pipe<=0, clear counter<=0.
//   - Outputs: Busy_SO=0, Gnt_SO=0, RValid_SO=0, RamCSel_SO=0.
//   - Reset mid-sweep aborts the sweep. With CLEAR_ON_RST=1 the sweep restarts at addr 0 on the first cycle after reset.
//  FSM states:
//   - IDLE: Gnt_SO = rr_winner(Req_SI), combinational, same cycle; no wait states.
//   - CLEAR: Gnt_SO=0. RAM driven with CSel=1, WrEn=1, BEn=4'hF, data=CLEAR_VAL, addr=counter.
//   - IDLE->CLEAR: on Clear_SI=1, or on the first cycle after reset when CLEAR_ON_RST=1.
//   - CLEAR->IDLE: in the cycle after the write to DATA_DEPTH-1. The sweep takes exactly DATA_DEPTH cycles.
//  Busy_SO is registered and equals (state==CLEAR). Clear_SI is ignored while in CLEAR.
//  Clear_SI together with a request in IDLE: the request is granted in that cycle; the sweep starts next cycle.
//  Round-robin arbitration:
//   - Priority starts at pointer p and searches upward with wrap.
//   - After a grant to port i, p<=(i+1)%NUM_PORTS. With no grant, p holds.
//   - A single requester is granted every cycle (100% throughput).
//  RAM drive in IDLE:
//   - Winner's WrEn/BEn/WrData/Addr are muxed to the Ram* outputs; RamCSel_SO=|Gnt_SO.
//   - With no winner, Ram* data outputs are 0 and RamCSel_SO=0.
//  Responses:
//   - Every grant, read or write, produces exactly one RValid_SO pulse on the granted port, RD_LAT cycles later.
//   - Writes are acked with RdData_DO = RAM output (don't care).
//   - Tracking uses a shift register of RD_LAT one-hot entries, so back-to-back grants are fully pipelined.
//   - Responses still in flight when a sweep starts are delivered normally.
//   - RdData_DO = RamRdData_DI, passed through combinationally.
//  Addr_DI >= DATA_DEPTH: the access is forwarded unchanged; behaviour is the RAM's.
// STRUCTURE
//  Package sp_ram_arb_pkg:
//   - state enum state_e {IDLE, CLEAR}
//   - localparam DATA_BYTES=4
//  Sub-module rr_arbiter #(NUM_PORTS):
//   - inputs req, ptr; output one-hot gnt.
//   - Purely combinational; the pointer register lives in the parent.
//  Parent holds the FSM, clear counter, pointer register and rvalid pipe.
// TESTING
//  1. Sweep + read back (CLEAR_ON_RST=1, DATA_DEPTH=16):
//     release reset -> Busy_SO=1 for exactly 16 cycles, addr 0..15 written with 0.
//     Then a read of addr 5 -> RValid 1 cycle later, data 0.
//  2. Round-robin fairness: Req_SI=2'b11 held for 6 cycles -> Gnt_SO = 01,10,01,10,01,10.
//     Each RValid follows its grant by RD_LAT.
//  3. Byte-enable write: port1 writes 32'hAABBCCDD with BEn 4'b0101 to addr 3 after a clear.
//     Port0 then reads addr 3 -> 32'h00BB00DD.
//  4. OUT_REGS=1: back-to-back reads addr 1,2,3 on port0 -> RValid on 3 consecutive cycles, 2 cycles after each grant.
//     Data is returned in order.
//  5. Clear_SI with Req_SI=01 in the same cycle -> port0 granted that cycle and its RValid is delivered.
//     No grants while Busy_SO=1; pending Req is granted on the first cycle after the sweep.
//  6. Rst_SI asserted mid-sweep (CLEAR_ON_RST=0) -> next cycle Busy_SO=0, Gnt_SO=0, RValid_SO=0.
//     Ram CSel is low until the next request.

Source files
------------

// File: rtl/sp_ram_arb_pkg.sv
// Shared types and constants for the single-port RAM arbiter.
//   state_e    : arbiter FSM states (IDLE serves requesters, CLEAR sweeps the RAM)
//   DATA_BYTES : byte lanes per RAM word
//   DATA_WIDTH : RAM word width in bits
package sp_ram_arb_pkg;

    typedef enum logic [0:0] {
        IDLE,
        CLEAR
    } state_e;

    localparam int unsigned DATA_BYTES = 4;
    localparam int unsigned DATA_WIDTH = 8 * DATA_BYTES;

endpackage

// File: rtl/sp_ram_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
//   req : per-port request vector
//   ptr : index of the highest-priority port this cycle
//   gnt : one-hot grant, or zero when nothing is requested
// The search starts at ptr and wraps upward; the pointer register lives in the parent.
module rr_arbiter #(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned PTR_WIDTH = 1
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PTR_WIDTH-1:0] ptr,
    output logic [NUM_PORTS-1:0] gnt
);

    logic                 found;
    logic [PTR_WIDTH-1:0] idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned off = 0; off < NUM_PORTS; off++) begin
            idx = PTR_WIDTH'((32'(ptr) + off) % NUM_PORTS);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sp_ram_arbiter.sv
// Shares one synchronous single-port byte-enable RAM among NUM_PORTS requesters.
// Ports:
//   Clk_CI, Rst_SI           : clock, synchronous active-high reset
//   Clear_SI / Busy_SO       : start a clear sweep / sweep in progress
//   Req_SI / Gnt_SO          : per-port request / same-cycle one-hot grant
//   WrEn_SI, BEn_SI,
//   WrData_DI, Addr_DI       : per-port access fields, packed port-major
//   RValid_SO / RdData_DO    : per-port response strobe (RD_LAT after grant) / shared data
//   RamCSel_SO .. RamAddr_DO : drive to the external RAM macro
//   RamRdData_DI             : RAM read data
module sp_ram_arbiter
    import sp_ram_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS    = 2,
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned DATA_DEPTH   = 1024,
    parameter int unsigned OUT_REGS     = 0,
    parameter logic [31:0] CLEAR_VAL    = 32'h0,
    parameter int unsigned CLEAR_ON_RST = 0
) (
    input  logic                             Clk_CI,
    input  logic                             Rst_SI,
    input  logic                             Clear_SI,
    output logic                             Busy_SO,
    input  logic [NUM_PORTS-1:0]             Req_SI,
    output logic [NUM_PORTS-1:0]             Gnt_SO,
    input  logic [NUM_PORTS-1:0]             WrEn_SI,
    input  logic [NUM_PORTS*DATA_BYTES-1:0]  BEn_SI,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  WrData_DI,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  Addr_DI,
    output logic [NUM_PORTS-1:0]             RValid_SO,
    output logic [DATA_WIDTH-1:0]            RdData_DO,
    output logic                             RamCSel_SO,
    output logic                             RamWrEn_SO,
    output logic [DATA_BYTES-1:0]            RamBEn_SO,
    output logic [DATA_WIDTH-1:0]            RamWrData_DO,
    output logic [ADDR_WIDTH-1:0]            RamAddr_DO,
    input  logic [DATA_WIDTH-1:0]            RamRdData_DI
);

    localparam int unsigned RD_LAT    = 1 + OUT_REGS;
    localparam int unsigned PTR_WIDTH = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DATA_DEPTH - 1);

    state_e                              state_q, state_d;
    logic [ADDR_WIDTH-1:0]               clr_cnt_q, clr_cnt_d;
    logic [PTR_WIDTH-1:0]                ptr_q, ptr_d;
    logic [RD_LAT-1:0][NUM_PORTS-1:0]    rvalid_q;
    // Set by reset so the auto-clear starts on the first cycle after release.
    logic                                rst_pend_q;
    logic [NUM_PORTS-1:0]                arb_gnt;

    rr_arbiter #(
        .NUM_PORTS(NUM_PORTS),
        .PTR_WIDTH(PTR_WIDTH)
    ) u_rr_arbiter (
        .req(Req_SI),
        .ptr(ptr_q),
        .gnt(arb_gnt)
    );

    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        ptr_d        = ptr_q;
        Gnt_SO       = '0;
        RamCSel_SO   = 1'b0;
        RamWrEn_SO   = 1'b0;
        RamBEn_SO    = '0;
        RamWrData_DO = '0;
        RamAddr_DO   = '0;

        unique case (state_q)
            IDLE: begin
                Gnt_SO     = arb_gnt;
                RamCSel_SO = |arb_gnt;
                for (int i = 0; i < int'(NUM_PORTS); i++) begin
                    if (arb_gnt[i]) begin
                        RamWrEn_SO   = WrEn_SI[i];
                        RamBEn_SO    = BEn_SI[i*DATA_BYTES +: DATA_BYTES];
                        RamWrData_DO = WrData_DI[i*DATA_WIDTH +: DATA_WIDTH];
                        RamAddr_DO   = Addr_DI[i*ADDR_WIDTH +: ADDR_WIDTH];
                        ptr_d        = (i == int'(NUM_PORTS) - 1) ? '0 : PTR_WIDTH'(i + 1);
                    end
                end
                // A request in the same cycle is still served; the sweep begins next cycle.
                if (Clear_SI || rst_pend_q) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                end
            end
            CLEAR: begin
                RamCSel_SO   = 1'b1;
                RamWrEn_SO   = 1'b1;
                RamBEn_SO    = '1;
                RamWrData_DO = CLEAR_VAL;
                RamAddr_DO   = clr_cnt_q;
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d   = IDLE;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk_CI) begin
        if (Rst_SI) begin
            state_q    <= IDLE;
            clr_cnt_q  <= '0;
            ptr_q      <= '0;
            rvalid_q   <= '0;
            rst_pend_q <= (CLEAR_ON_RST != 0);
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            ptr_q       <= ptr_d;
            rst_pend_q  <= 1'b0;
            // One-hot grant history; in-flight entries drain normally during a sweep.
            rvalid_q[0] <= Gnt_SO;
            for (int k = 1; k < int'(RD_LAT); k++) begin
                rvalid_q[k] <= rvalid_q[k-1];
            end
        end
    end

    assign Busy_SO   = (state_q == CLEAR);
    assign RValid_SO = rvalid_q[RD_LAT-1];
    assign RdData_DO = RamRdData_DI;

endmodule
